// File: rtl/scm_fifo_pkg.sv
// Shared defaults and helper types for the SCM-backed streaming FIFO controller.
package scm_fifo_pkg;

  localparam int unsigned SCM_ADDR_WIDTH = 5;
  localparam int unsigned SCM_DATA_WIDTH = 32;
  localparam int unsigned SCM_DEPTH      = 2 ** SCM_ADDR_WIDTH;
  localparam int unsigned SCM_CNT_WIDTH  = SCM_ADDR_WIDTH + 2;

  // Extra MSB distinguishes full from empty when the address bits match.
  typedef logic [SCM_ADDR_WIDTH:0] scm_fifo_ptr_t;

endpackage

// File: rtl/scm_fifo_out_buf.sv
// Two-entry in-order output buffer; entry 0 is always the head word.
module scm_fifo_out_buf
  import scm_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SCM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  pop_i,
  output logic [1:0]            cnt_o,
  output logic [DATA_WIDTH-1:0] head_data_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]            cnt_q, cnt_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else begin
      unique case ({wr_en_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = wr_data_i;
          else               ent1_d = wr_data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous land and pop: occupancy holds, the new word goes behind any survivor.
          if (cnt_q == 2'd2) begin
            ent0_d = ent1_q;
            ent1_d = wr_data_i;
          end else begin
            ent0_d = wr_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign head_data_o = ent0_q;

endmodule

// File: rtl/scm_fifo_ctrl.sv
// Valid/ready FIFO controller driving an external 1W/NR flop register file with a
// one-cycle registered read, plus a 2-entry output buffer to hide that latency.
module scm_fifo_ctrl
  import scm_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SCM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SCM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  pop_valid_o,
  input  logic                  pop_ready_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [ADDR_WIDTH+1:0] fill_count_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  rf_re_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i
);

  localparam logic [ADDR_WIDTH:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] s_cnt;
  logic                in_flight_q, in_flight_d;
  logic [1:0]          ob_cnt;
  logic [2:0]          ob_pending;
  logic                push_fire, pop_fire, fetch, land;

  assign s_cnt        = wr_ptr_q - rd_ptr_q;
  assign push_ready_o = (s_cnt != DEPTH_P) && !flush_i;
  assign push_fire    = push_valid_i && push_ready_o;
  assign pop_valid_o  = (ob_cnt != 2'd0);
  assign pop_fire     = pop_valid_o && pop_ready_i && !flush_i;

  // Only fetch if the word is guaranteed a buffer slot when it lands next cycle.
  assign ob_pending = {1'b0, ob_cnt} + {2'b00, in_flight_q} - {2'b00, pop_fire};
  assign fetch      = (s_cnt != '0) && (ob_pending < 3'd2) && !flush_i;
  assign land       = in_flight_q && !flush_i;

  assign rf_we_o    = push_fire;
  assign rf_waddr_o = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rf_wdata_o = push_data_i;
  assign rf_re_o    = fetch;
  assign rf_raddr_o = rd_ptr_q[ADDR_WIDTH-1:0];

  assign fill_count_o = {1'b0, s_cnt}
                      + (ADDR_WIDTH+2)'(in_flight_q)
                      + (ADDR_WIDTH+2)'(ob_cnt);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    in_flight_d = fetch;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (fetch)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_flight_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_flight_q <= in_flight_d;
    end
  end

  scm_fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (flush_i),
    .wr_en_i     (land),
    .wr_data_i   (rf_rdata_i),
    .pop_i       (pop_fire),
    .cnt_o       (ob_cnt),
    .head_data_o (pop_data_o)
  );

endmodule

// File: tb/tb_scm_fifo_ctrl.sv
// Directed bench for scm_fifo_ctrl with a one-cycle-latency register-file model beside it.
`timescale 1ns/1ps
module tb_scm_fifo_ctrl;
  import scm_fifo_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = SCM_DEPTH;
  localparam int CAP   = DEPTH + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [DW-1:0] push_data = '0;
  logic          pop_valid;
  logic          pop_ready = 1'b0;
  logic [DW-1:0] pop_data;
  logic [AW+1:0] fill;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_re;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q = '0;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we) mem[rf_waddr] <= rf_wdata;
    if (rf_re) rdata_q <= mem[rf_raddr];
  end
  assign rf_rdata = rdata_q;

  scm_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .push_data_i  (push_data),
    .pop_valid_o  (pop_valid),
    .pop_ready_i  (pop_ready),
    .pop_data_o   (pop_data),
    .fill_count_o (fill),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .rf_re_o      (rf_re),
    .rf_raddr_o   (rf_raddr),
    .rf_rdata_i   (rf_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_push_ready"}, push_ready, 1);
    check({tag, "_pop_valid"},  pop_valid,  0);
    check({tag, "_pop_data"},   pop_data,   0);
    check({tag, "_fill"},       fill,       0);
    check({tag, "_rf_we"},      rf_we,      0);
    check({tag, "_rf_re"},      rf_re,      0);
    check({tag, "_rf_raddr"},   rf_raddr,   0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, exp_idx, cyc, sent, popped, bubbles, wraps, maxfill;
    bit first, got;
    logic [DW-1:0] w;

    // Power-on reset
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single word latency: push in cycle 0, pop visible in cycle 3
    push_valid = 1'b1; push_data = 32'hA5A5_0001; pop_ready = 1'b1;
    settle();
    check("c0_rf_we", rf_we, 1);
    check("c0_rf_waddr", rf_waddr, 0);
    check("c0_rf_wdata", rf_wdata, 32'hA5A5_0001);
    check("c0_fill", fill, 0);
    tick();
    push_valid = 1'b0;
    settle();
    check("c1_rf_re", rf_re, 1);
    check("c1_rf_raddr", rf_raddr, 0);
    check("c1_fill", fill, 1);
    check("c1_pop_valid", pop_valid, 0);
    tick(); settle();
    check("c2_fill", fill, 1);
    check("c2_pop_valid", pop_valid, 0);
    check("c2_rf_re", rf_re, 0);
    tick(); settle();
    check("c3_pop_valid", pop_valid, 1);
    check("c3_pop_data", pop_data, 32'hA5A5_0001);
    check("c3_fill", fill, 1);
    tick(); settle();
    check("c4_fill", fill, 0);
    check("c4_pop_valid", pop_valid, 0);
    tick();

    // Fill to capacity with the sink stalled
    pop_ready = 1'b0; acc = 0;
    for (int i = 0; i < 40; i++) begin
      push_valid = 1'b1; push_data = acc;
      settle();
      if (push_ready) acc++;
      tick();
    end
    push_valid = 1'b0;
    settle();
    check("full_accepted", acc, CAP);
    check("full_push_ready", push_ready, 0);
    check("full_fill", fill, CAP);
    check("full_pop_valid", pop_valid, 1);
    pop_ready = 1'b1;
    settle();
    check("full_pop_no_reopen", push_ready, 0);
    check("full_pop_drives_re", rf_re, 1);
    check("drain_data_0", pop_data, 0);
    tick(); settle();
    check("full_reopen_next", push_ready, 1);
    exp_idx = 1; cyc = 0;
    while (exp_idx < CAP && cyc < 200) begin
      if (pop_valid) begin
        check($sformatf("drain_data_%0d", exp_idx), pop_data, exp_idx);
        exp_idx++;
      end
      tick(); settle(); cyc++;
    end
    check("drain_count", exp_idx, CAP);
    check("drain_fill", fill, 0);
    check("drain_pop_valid", pop_valid, 0);
    tick();

    // Continuous streaming: no bubbles once primed, addresses wrap
    sent = 0; popped = 0; bubbles = 0; wraps = 0; first = 0; cyc = 0;
    while (popped < 100 && cyc < 1000) begin
      push_valid = (sent < 100); push_data = 32'hC000_0000 + sent; pop_ready = 1'b1;
      settle();
      if (push_valid && push_ready) begin
        sb.push_back(push_data);
        sent++;
        if (rf_waddr == '0) wraps++;
      end
      if (pop_valid) begin
        first = 1;
        if (sb.size() == 0) check("stream_unexpected_pop", 1, 0);
        else begin w = sb.pop_front(); check("stream_data", pop_data, w); end
        popped++;
      end else if (first) bubbles++;
      tick(); cyc++;
    end
    push_valid = 1'b0;
    check("stream_count", popped, 100);
    check("stream_bubbles", bubbles, 0);
    check("stream_wraps_ge3", (wraps >= 3), 1);

    // Random backpressure with scoreboard
    sent = 0; popped = 0; maxfill = 0; cyc = 0;
    while (popped < 500 && cyc < 20000) begin
      push_valid = (sent < 500) && ($urandom_range(0, 3) != 0);
      push_data  = $urandom;
      pop_ready  = $urandom_range(0, 1);
      settle();
      if (int'(fill) > maxfill) maxfill = int'(fill);
      if (push_valid && push_ready) begin sb.push_back(push_data); sent++; end
      if (pop_valid && pop_ready) begin
        if (sb.size() == 0) check("rand_unexpected_pop", 1, 0);
        else begin w = sb.pop_front(); check("rand_data", pop_data, w); end
        popped++;
      end
      tick(); cyc++;
    end
    push_valid = 1'b0; pop_ready = 1'b0;
    check("rand_count", popped, 500);
    check("rand_sb_empty", sb.size(), 0);
    check("rand_fill_le_cap", (maxfill <= CAP), 1);
    for (int i = 0; i < 4; i++) tick();
    settle();
    check("rand_end_fill", fill, 0);
    tick();

    // Flush with a word landing and one in the buffer
    pop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_data = 32'hF000_0000 + i;
      settle(); tick();
    end
    push_valid = 1'b0;
    settle();
    check("preflush_fill", fill, 3);
    check("preflush_rf_re", rf_re, 0);
    flush = 1'b1;
    settle();
    check("flush_push_ready", push_ready, 0);
    check("flush_rf_re", rf_re, 0);
    tick();
    flush = 1'b0;
    settle();
    check("postflush_pop_valid", pop_valid, 0);
    check("postflush_fill", fill, 0);
    push_valid = 1'b1; push_data = 32'h0000_1234; pop_ready = 1'b1;
    settle();
    check("postflush_waddr", rf_waddr, 0);
    tick();
    push_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      settle();
      if (pop_valid) got = 1; else tick();
    end
    check("postflush_pop_seen", got, 1);
    check("postflush_first_data", pop_data, 32'h0000_1234);
    tick(); settle();
    check("postflush_no_stale", pop_valid, 0);
    check("postflush_empty", fill, 0);
    tick();

    // Asynchronous reset mid-stream
    pop_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_valid = 1'b1; push_data = 32'hDD00_0000 + i;
      settle(); tick();
    end
    push_valid = 1'b0;
    settle();
    check("prereset_fill", fill, 5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick(); tick();
    rst_n = 1'b1;
    settle();
    check("postreset_fill", fill, 0);
    check("postreset_pop_valid", pop_valid, 0);
    tick();
    push_valid = 1'b1; push_data = 32'h0000_BEEF; pop_ready = 1'b1;
    settle();
    check("postreset_waddr", rf_waddr, 0);
    tick();
    push_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      settle();
      if (pop_valid) got = 1; else tick();
    end
    check("postreset_pop_seen", got, 1);
    check("postreset_data", pop_data, 32'h0000_BEEF);
    tick(); settle();
    check("postreset_final_fill", fill, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
